// File: rtl/rw_arb_pkg.sv
// Shared types and widths for the ReadWrite transaction arbiter.
package rw_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        BACKOFF,
        RESP
    } state_t;

    function automatic int unsigned retry_w(input int unsigned max_retry);
        return $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_picker #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rw_arbiter.sv
// Round-robin arbiter sharing one ReadWrite transaction FSM between NUM_REQ
// requesters, with cancel/back-off retry and per-requester responses.
module rw_arbiter
    import rw_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 4,
    localparam int unsigned RW = (retry_w(MAX_RETRY) > 0) ? retry_w(MAX_RETRY) : 1
) (
    input  logic                        clk,
    input  logic                        rst_L,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic                        resp_err,
    output logic [RW-1:0]               resp_retries,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        rw_read,
    output logic                        rw_tran_ready,
    output logic [ADDR_W-1:0]           rw_addr,
    output logic [DATA_W-1:0]           rw_data_down,
    input  logic                        rw_done,
    input  logic                        rw_cancel,
    input  logic                        rw_recv_ready,
    input  logic [DATA_W-1:0]           rw_data_up
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = $clog2(BACKOFF_CYC + 1);

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        idx_q;
    logic [RW-1:0]        retries;
    logic [BW-1:0]        boff;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_grant = (state == IDLE && rst_L) ? pick_grant : '0;

    // rw_read/rw_addr/rw_data_down are the latched operands themselves, so they
    // stay stable from ISSUE until done and across every retry.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state         <= IDLE;
            ptr           <= IW'(NUM_REQ - 1);
            idx_q         <= '0;
            retries       <= '0;
            boff          <= '0;
            rw_read       <= 1'b0;
            rw_addr       <= '0;
            rw_data_down  <= '0;
            rw_tran_ready <= 1'b0;
            resp_valid    <= '0;
            resp_err      <= 1'b0;
            resp_retries  <= '0;
            resp_data     <= '0;
        end else begin
            rw_tran_ready <= 1'b0;
            resp_valid    <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        rw_read       <= req_read[pick_idx];
                        rw_addr       <= req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
                        rw_data_down  <= req_wdata[32'(pick_idx)*DATA_W +: DATA_W];
                        idx_q         <= pick_idx;
                        ptr           <= pick_idx;
                        retries       <= '0;
                        rw_tran_ready <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: state <= BUSY;
                BUSY: begin
                    if (rw_done) begin
                        if (!rw_cancel) begin
                            resp_data    <= (rw_read && rw_recv_ready) ? rw_data_up : '0;
                            resp_err     <= 1'b0;
                            resp_retries <= retries;
                            resp_valid   <= NUM_REQ'(1) << idx_q;
                            state        <= RESP;
                        end else if (32'(retries) < MAX_RETRY) begin
                            retries <= retries + RW'(1);
                            boff    <= BW'(BACKOFF_CYC);
                            state   <= BACKOFF;
                        end else begin
                            resp_data    <= '0;
                            resp_err     <= 1'b1;
                            resp_retries <= retries;
                            resp_valid   <= NUM_REQ'(1) << idx_q;
                            state        <= RESP;
                        end
                    end
                end
                BACKOFF: begin
                    boff <= boff - BW'(1);
                    if (boff == BW'(1)) begin
                        rw_tran_ready <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rw_arbiter.sv
// Self-checking bench for rw_arbiter: cycle table plus directed corner sequences.
module tb_rw_arbiter;

    logic          clk = 1'b0;
    logic          rst_L;
    logic [1:0]    req_valid;
    logic [1:0]    req_read;
    logic [31:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [1:0]    req_grant;
    logic [1:0]    resp_valid;
    logic          resp_err;
    logic [1:0]    resp_retries;
    logic [63:0]   resp_data;
    logic          rw_read;
    logic          rw_tran_ready;
    logic [15:0]   rw_addr;
    logic [63:0]   rw_data_down;
    logic          rw_done;
    logic          rw_cancel;
    logic          rw_recv_ready;
    logic [63:0]   rw_data_up;

    always #5 clk = ~clk;

    rw_arbiter #(.NUM_REQ(2), .MAX_RETRY(3), .BACKOFF_CYC(4)) dut (
        .clk           (clk),
        .rst_L         (rst_L),
        .req_valid     (req_valid),
        .req_read      (req_read),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_grant     (req_grant),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_retries  (resp_retries),
        .resp_data     (resp_data),
        .rw_read       (rw_read),
        .rw_tran_ready (rw_tran_ready),
        .rw_addr       (rw_addr),
        .rw_data_down  (rw_data_down),
        .rw_done       (rw_done),
        .rw_cancel     (rw_cancel),
        .rw_recv_ready (rw_recv_ready),
        .rw_data_up    (rw_data_up)
    );

    typedef struct {
        logic [1:0]  valid;
        logic        done;
        logic        cancel;
        logic        rr;
        logic [63:0] up;
        logic [1:0]  e_grant;
        logic        e_tr;
        logic [1:0]  e_rv;
        logic        e_rd;
        logic [15:0] e_addr;
        logic [63:0] e_rdata;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl [11];
        logic [1:0] rr_exp [4];
        int         k;
        int         npulse;
        int         got;
        int         bad;
        int         gcnt;
        int         trc;
        int         dbl;
        logic       prev_tr;

        tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 64'h0, 2'b01, 1'b0, 2'b00, 1'b0, 16'h0000, 64'h0};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 2'b00, 1'b1, 16'h1234, 64'h0};
        tbl[2]  = '{2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 2'b00, 1'b1, 16'h1234, 64'h0};
        tbl[3]  = '{2'b00, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D,
                    2'b00, 1'b0, 2'b00, 1'b1, 16'h1234, 64'h0};
        tbl[4]  = '{2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 2'b01, 1'b1, 16'h1234,
                    64'hDEADBEEF_CAFEF00D};
        tbl[5]  = '{2'b10, 1'b0, 1'b0, 1'b0, 64'h0, 2'b10, 1'b0, 2'b00, 1'b1, 16'h1234,
                    64'hDEADBEEF_CAFEF00D};
        tbl[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 2'b00, 1'b0, 16'h0042,
                    64'hDEADBEEF_CAFEF00D};
        tbl[7]  = '{2'b00, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                    2'b00, 1'b0, 2'b00, 1'b0, 16'h0042, 64'hDEADBEEF_CAFEF00D};
        tbl[8]  = '{2'b00, 1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 2'b10, 1'b0, 16'h0042, 64'h0};
        tbl[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0042, 64'h0};
        tbl[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0042, 64'h0};

        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;
        rr_exp[3] = 2'b10;

        rst_L         = 1'b0;
        req_valid     = 2'b00;
        req_read      = 2'b01;
        req_addr      = {16'h0042, 16'h1234};
        req_wdata     = {64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444};
        rw_done       = 1'b0;
        rw_cancel     = 1'b0;
        rw_recv_ready = 1'b0;
        rw_data_up    = 64'h0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 64'(req_grant), 64'h0);
        chk("rst_tr", 64'(rw_tran_ready), 64'h0);
        chk("rst_rv", 64'(resp_valid), 64'h0);
        chk("rst_addr", 64'(rw_addr), 64'h0);
        chk("rst_down", rw_data_down, 64'h0);
        chk("rst_rdata", resp_data, 64'h0);
        rst_L = 1'b1;

        // Single read, then a write from requester 1
        for (int i = 0; i < 11; i++) begin
            tick();
            req_valid     = tbl[i].valid;
            rw_done       = tbl[i].done;
            rw_cancel     = tbl[i].cancel;
            rw_recv_ready = tbl[i].rr;
            rw_data_up    = tbl[i].up;
            settle();
            chk($sformatf("v%0d_grant", i), 64'(req_grant), 64'(tbl[i].e_grant));
            chk($sformatf("v%0d_tr", i), 64'(rw_tran_ready), 64'(tbl[i].e_tr));
            chk($sformatf("v%0d_rv", i), 64'(resp_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d_rd", i), 64'(rw_read), 64'(tbl[i].e_rd));
            chk($sformatf("v%0d_addr", i), 64'(rw_addr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_rdata", i), resp_data, tbl[i].e_rdata);
        end

        // Write hold: payload changes after grant, latched copy stays
        tick();
        req_valid = 2'b10;
        settle();
        chk("wh_grant", 64'(req_grant), 64'h2);
        tick();
        req_valid = 2'b00;
        req_wdata[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        chk("wh_tr", 64'(rw_tran_ready), 64'h1);
        chk("wh_down_issue", rw_data_down, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk($sformatf("wh_down_busy%0d", i), rw_data_down, 64'h0123_4567_89AB_CDEF);
        end
        rw_done = 1'b1;
        tick();
        rw_done = 1'b0;
        settle();
        chk("wh_rv", 64'(resp_valid), 64'h2);
        chk("wh_rdata", resp_data, 64'h0);
        chk("wh_down_resp", rw_data_down, 64'h0123_4567_89AB_CDEF);

        // Single cancel: re-issue pulse BACKOFF_CYC+1 cycles after the done
        tick();
        req_valid = 2'b01;
        settle();
        chk("sc_grant", 64'(req_grant), 64'h1);
        tick();
        req_valid = 2'b00;
        settle();
        chk("sc_tr0", 64'(rw_tran_ready), 64'h1);
        tick();
        rw_done   = 1'b1;
        rw_cancel = 1'b1;
        k = 0;
        do begin
            tick();
            rw_done   = 1'b0;
            rw_cancel = 1'b0;
            k++;
            settle();
        end while (!rw_tran_ready && k < 20);
        chk("sc_gap", 64'(k), 64'd5);
        tick();
        rw_done       = 1'b1;
        rw_recv_ready = 1'b1;
        rw_data_up    = 64'hA5A5_5A5A_0F0F_F0F0;
        tick();
        rw_done       = 1'b0;
        rw_recv_ready = 1'b0;
        settle();
        chk("sc_rv", 64'(resp_valid), 64'h1);
        chk("sc_retries", 64'(resp_retries), 64'd1);
        chk("sc_err", 64'(resp_err), 64'h0);
        chk("sc_rdata", resp_data, 64'hA5A5_5A5A_0F0F_F0F0);

        // Retry exhaustion: every attempt cancelled
        tick();
        req_valid = 2'b10;
        rw_done   = 1'b1;
        rw_cancel = 1'b1;
        settle();
        chk("ex_grant", 64'(req_grant), 64'h2);
        npulse = 0;
        got    = 0;
        for (int c = 0; c < 100 && got == 0; c++) begin
            tick();
            req_valid = 2'b00;
            settle();
            if (rw_tran_ready) npulse++;
            if (resp_valid != 2'b00) got = 1;
        end
        chk("ex_resp_seen", 64'(got), 64'h1);
        chk("ex_pulses", 64'(npulse), 64'd4);
        chk("ex_rv", 64'(resp_valid), 64'h2);
        chk("ex_err", 64'(resp_err), 64'h1);
        chk("ex_retries", 64'(resp_retries), 64'd3);
        chk("ex_rdata", resp_data, 64'h0);
        rw_done   = 1'b0;
        rw_cancel = 1'b0;

        // Reset while BUSY drops the request
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        rst_L = 1'b0;
        tick();
        rst_L = 1'b1;
        settle();
        chk("rb_tr", 64'(rw_tran_ready), 64'h0);
        chk("rb_rv", 64'(resp_valid), 64'h0);
        chk("rb_rd", 64'(rw_read), 64'h0);
        chk("rb_addr", 64'(rw_addr), 64'h0);
        chk("rb_down", rw_data_down, 64'h0);
        chk("rb_err", 64'(resp_err), 64'h0);
        chk("rb_retries", 64'(resp_retries), 64'h0);
        rw_done = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            if (resp_valid != 2'b00) bad++;
        end
        chk("rb_no_resp", 64'(bad), 64'h0);

        // Round-robin after reset with both requesters held valid
        req_valid     = 2'b11;
        rw_recv_ready = 1'b1;
        rw_data_up    = 64'h5A5A_5A5A_5A5A_5A5A;
        settle();
        gcnt    = 0;
        trc     = 0;
        dbl     = 0;
        prev_tr = 1'b0;
        for (int c = 0; c < 60 && gcnt < 4; c++) begin
            if (c > 0) begin
                tick();
                settle();
            end
            if (rw_tran_ready) begin
                if (prev_tr) dbl++;
                trc++;
            end
            prev_tr = rw_tran_ready;
            if (req_grant != 2'b00) begin
                chk($sformatf("rr_grant%0d", gcnt), 64'(req_grant), 64'(rr_exp[gcnt]));
                gcnt++;
            end
        end
        tick();
        req_valid = 2'b00;
        settle();
        if (rw_tran_ready) trc++;
        chk("rr_grants", 64'(gcnt), 64'd4);
        chk("rr_tr_pulses", 64'(trc), 64'd4);
        chk("rr_double_tr", 64'(dbl), 64'd0);
        tick();
        tick();
        settle();
        chk("rr_last_rv", 64'(resp_valid), 64'h2);
        chk("rr_last_retries", 64'(resp_retries), 64'h0);
        rw_done       = 1'b0;
        rw_recv_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
